// File: rtl/ssd_mux_controller.sv
// Two-digit PmodSSD scanner: double-buffered byte, per-slot blanking, hex decode.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN darkens a zero MSB digit.
module ssd_mux_controller #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic [6:0] digit_out,
  output logic       sel_out,
  output logic       frame_tick
);

  localparam int SLOT = CLK_HZ / REFRESH_HZ;
  localparam int SHOW = SLOT - BLANK_CYCLES;
  localparam int CW   = (SLOT > 2) ? $clog2(SLOT) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BLANK_LSB,
    S_SHOW_LSB,
    S_BLANK_MSB,
    S_SHOW_MSB
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_last;

  logic [7:0]    r_active;
  logic [7:0]    r_pend;
  logic          r_pend_full;
  logic          r_ready;
  logic          w_accept;
  logic          w_xfer;
  logic          w_full_nxt;

  logic [6:0]    r_digit;
  logic          r_sel;
  logic          r_tick;
  logic [6:0]    w_digit_nxt;
  logic          w_sel_nxt;
  logic          w_tick_nxt;
  logic [6:0]    w_seg_lo;
  logic [6:0]    w_seg_hi;

  function automatic logic [6:0] hex7seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_seg_lo = hex7seg(r_active[3:0]);
`ifdef SSD_LEADING_ZERO_BLANK_EN
  assign w_seg_hi = (r_active[7:4] == 4'h0) ? 7'h00
                                             : hex7seg(r_active[7:4]);
`else
  assign w_seg_hi = hex7seg(r_active[7:4]);
`endif

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      S_BLANK_LSB,
      S_BLANK_MSB: w_last = (r_cnt == BLANK_LAST);
      S_SHOW_LSB,
      S_SHOW_MSB:  w_last = (r_cnt == SHOW_LAST);
      default:     w_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_ONE;
    if (r_state == S_IDLE) begin
      w_cnt_nxt = '0;
      if (enable) w_state_nxt = S_BLANK_LSB;
    end else if (!enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (w_last) begin
      w_cnt_nxt = '0;
      case (r_state)
        S_BLANK_LSB: w_state_nxt = S_SHOW_LSB;
        S_SHOW_LSB:  w_state_nxt = S_BLANK_MSB;
        S_BLANK_MSB: w_state_nxt = S_SHOW_MSB;
        S_SHOW_MSB:  w_state_nxt = S_BLANK_LSB;
        default:     w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Dropping enable darkens the display on the very next cycle.
  always_comb begin
    w_digit_nxt = 7'h00;
    w_sel_nxt   = 1'b0;
    w_tick_nxt  = 1'b0;
    if (enable) begin
      case (r_state)
        S_SHOW_LSB: w_digit_nxt = w_seg_lo;
        S_BLANK_MSB: w_sel_nxt = 1'b1;
        S_SHOW_MSB: begin
          w_sel_nxt   = 1'b1;
          w_digit_nxt = w_seg_hi;
          w_tick_nxt  = (r_cnt == SHOW_LAST);
        end
        default: w_digit_nxt = 7'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit <= 7'h00;
      r_sel   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_digit <= w_digit_nxt;
      r_sel   <= w_sel_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // Accept and transfer are exclusive: ready implies pending is empty.
  assign w_accept   = load_valid & r_ready;
  assign w_xfer     = r_pend_full & ((r_state == S_IDLE) | r_tick);
  assign w_full_nxt = w_accept | (r_pend_full & ~w_xfer);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active    <= 8'h00;
      r_pend      <= 8'h00;
      r_pend_full <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      if (w_xfer)   r_active <= r_pend;
      if (w_accept) r_pend   <= load_data;
      r_pend_full <= w_full_nxt;
      r_ready     <= ~w_full_nxt;
    end
  end

  assign load_ready = r_ready;
  assign digit_out  = r_digit;
  assign sel_out    = r_sel;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_ssd_mux_controller.sv
// Scoreboard bench for ssd_mux_controller (SLOT=10, BLANK=2).
// Accepted bytes queue up and become the expected display at each transfer.
module tb_ssd_mux_controller;

  localparam int CLK_HZ       = 100;
  localparam int REFRESH_HZ   = 10;
  localparam int BLANK_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic [6:0] digit_out;
  logic       sel_out;
  logic       frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb [$];
  logic [7:0] r_cur;
  logic       r_idle;

  logic [6:0] seg_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  ssd_mux_controller #(
    .CLK_HZ      (CLK_HZ),
    .REFRESH_HZ  (REFRESH_HZ),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .digit_out (digit_out),
    .sel_out   (sel_out),
    .frame_tick(frame_tick)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] msb_seg(input logic [3:0] n);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    return (n == 4'h0) ? 7'h00 : seg_tbl[n];
`else
    return seg_tbl[n];
`endif
  endfunction

  // Reference model of the double buffer.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      r_cur  <= 8'h00;
      r_idle <= 1'b1;
    end else begin
      if ((r_idle || frame_tick) && sb.size() > 0)
        r_cur <= sb.pop_front();
      if (load_valid && load_ready)
        sb.push_back(load_data);
      r_idle <= !enable;
    end
  end

  task automatic wait_tick();
    int n = 0;
    while (!frame_tick && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tick_wait", frame_tick, 1'b1);
  endtask

  task automatic check_frame(input string tag);
    logic [6:0] ed;
    logic       es;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      es = (k >= 10);
      if ((k % 10) < 2)
        ed = 7'h00;
      else if (k < 10)
        ed = seg_tbl[r_cur[3:0]];
      else
        ed = msb_seg(r_cur[7:4]);
      chk({tag, "_sel"}, sel_out, es);
      chk({tag, "_dig"}, digit_out, ed);
      chk({tag, "_tick"}, frame_tick, k == 19);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_dig", digit_out, 7'h00);
    chk("rst_sel", sel_out, 1'b0);
    chk("rst_tick", frame_tick, 1'b0);
    chk("rst_rdy", load_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_rise", load_ready, 1'b1);
    chk("idle_dig", digit_out, 7'h00);

    // Load 3A as scanning starts; shown the frame after the first tick.
    enable     = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h3A;
    @(negedge clk);
    load_valid = 1'b0;
    chk("rdy_acc3a", load_ready, 1'b0);
    wait_tick();
    check_frame("f3a");
    wait_tick();
    check_frame("steady");

    // Back-to-back 12 then 34; 34 waits for the boundary.
    repeat (5) @(negedge clk);
    load_valid = 1'b1;
    load_data  = 8'h12;
    chk("rdy_pre12", load_ready, 1'b1);
    @(negedge clk);
    chk("rdy_acc12", load_ready, 1'b0);
    load_data = 8'h34;
    fork
      begin
        wait_tick();
        check_frame("f12");
      end
      begin
        wait_tick();
        chk("rdy_hold", load_ready, 1'b0);
        @(negedge clk);
        chk("rdy_free", load_ready, 1'b1);
        @(negedge clk);
        load_valid = 1'b0;
        chk("rdy_acc34", load_ready, 1'b0);
      end
    join
    wait_tick();
    check_frame("f34");

    // Disable during SHOW_MSB, then re-enable.
    repeat (14) @(negedge clk);
    chk("msb_sel", sel_out, 1'b1);
    chk("msb_dig", digit_out, msb_seg(r_cur[7:4]));
    enable = 1'b0;
    @(negedge clk);
    chk("dis_dig", digit_out, 7'h00);
    chk("dis_sel", sel_out, 1'b0);
    chk("dis_tick", frame_tick, 1'b0);
    repeat (3) @(negedge clk);
    chk("dark_dig", digit_out, 7'h00);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_idle", digit_out, 7'h00);
    check_frame("reen");

    // Reset with pending full discards everything.
    repeat (5) @(negedge clk);
    load_valid = 1'b1;
    load_data  = 8'h56;
    chk("rdy_pre56", load_ready, 1'b1);
    @(negedge clk);
    load_valid = 1'b0;
    chk("rdy_acc56", load_ready, 1'b0);
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("mrst_dig", digit_out, 7'h00);
    chk("mrst_sel", sel_out, 1'b0);
    chk("mrst_rdy", load_ready, 1'b0);
    chk("mrst_tick", frame_tick, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_post", load_ready, 1'b1);
    enable = 1'b1;
    wait_tick();
    check_frame("zero");

    // Leading zero on the MSB digit.
    repeat (3) @(negedge clk);
    load_valid = 1'b1;
    load_data  = 8'h05;
    chk("rdy_pre05", load_ready, 1'b1);
    @(negedge clk);
    load_valid = 1'b0;
    wait_tick();
    check_frame("f05");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
